clock_manager: RTL
==================

CLOCK_MANAGER -- requirements
Module: clock_manager

Interface
REQ-001 SHALL have parameter NUM_CH, default 2: number of clock-enable strobe channels (1..8).
REQ-002 SHALL have parameter DIV_WIDTH, default 8: width of each channel's divide value.
REQ-003 SHALL have parameter STABLE_CYCLES, default 1024: consecutive synchronised-lock cycles required before reset release (>=2).
REQ-004 SHALL have port clock_in  input  1: single system clock (PLL core output); all logic on rising edge.
REQ-005 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-006 SHALL have port locked  input  1: PLL lock flag, asynchronous to clock_in.
REQ-007 SHALL have port div  input  NUM_CH*DIV_WIDTH: per-channel divide values; channel k occupies bits [k*DIV_WIDTH +: DIV_WIDTH].
REQ-008 SHALL have port div_load  input  NUM_CH: per-channel one-cycle request to capture div into the channel's shadow register.
REQ-009 SHALL have port ch_en  input  NUM_CH: per-channel strobe enable (level).
REQ-010 SHALL have port sys_reset  output  1: synchronous active-high reset for downstream logic.
REQ-011 SHALL have port ready  output  1: high only in state RUN.
REQ-012 SHALL have port strobe  output  NUM_CH: per-channel one-cycle clock-enable pulses.

Function
REQ-013 SHALL pass locked through a 2-flop synchroniser; lock_s denotes its output (2-cycle latency).
REQ-014 SHALL implement states WAIT_LOCK, STABILISE, RUN.
REQ-015 WAIT_LOCK: go to STABILISE when lock_s=1; stable counter cleared.
REQ-016 STABILISE: count cycles with lock_s=1; go to RUN after STABLE_CYCLES consecutive cycles; lock_s=0 returns to WAIT_LOCK with counter cleared.
REQ-017 RUN: lock_s=0 returns to WAIT_LOCK in the next cycle.
REQ-018 sys_reset SHALL be registered, high in WAIT_LOCK and STABILISE, low in RUN; ready = not sys_reset.
REQ-019 Each channel SHALL hold an active divide register; div_load[k] captures div slice into a shadow register (any state); shadow copies into active register when the channel counter wraps, or immediately while not in RUN.
REQ-020 Channel counter SHALL be 0 on the first RUN cycle, increment each RUN cycle, assert strobe[k] (registered) in the cycle counter equals active divide, and wrap to 0 that same cycle: period = divide+1 cycles.
REQ-021 divide=0 SHALL give strobe[k] high every RUN cycle.
REQ-022 ch_en[k]=0 SHALL force strobe[k] low and hold counter at 0; re-enable restarts at count 0 (first strobe after divide+1 cycles).
REQ-023 div_load and wrap in the same cycle: new value applies at this wrap (load has priority, not lost).
REQ-024 strobe SHALL be all-zero whenever not in RUN; leaving RUN clears all counters.

Reset
REQ-025 reset=1 SHALL give next cycle: state WAIT_LOCK, sys_reset=1, ready=0, strobe=0, synchroniser flops 0, counters 0, active and shadow divide registers all-ones (max period).
REQ-026 reset mid-RUN SHALL abort strobes immediately the next cycle; reset has priority over div_load and lock.

Structure
REQ-027 Shared package clock_manager_pkg SHALL hold the state enum and default parameter constants.
REQ-028 One sub-module clock_divider_channel (counter, shadow/active divide, strobe) SHALL be instantiated NUM_CH times via generate.
REQ-029 No derived or gated clocks; all outputs are clock enables.

Verification
REQ-030 locked=1 from cycle 0, STABLE_CYCLES=16 -> sys_reset falls exactly 2+1+16 cycles after reset deassertion (sync + WAIT_LOCK + count); ready rises same cycle.
REQ-031 locked drops for 1 cycle at STABILISE count 10 -> returns to WAIT_LOCK, full 16-cycle count restarts; no premature release.
REQ-032 RUN, div ch0=3, ch1=0, both enabled -> ch0 strobes on RUN cycles 3,7,11; ch1 strobes every cycle.
REQ-033 ch0 div=3 running, div_load with 5 at count 1 -> next strobe still at count 3, following period 6 cycles.
REQ-034 locked falls in RUN -> within 3 cycles sys_reset=1, ready=0, strobe=0; relock repeats full STABILISE.
REQ-035 reset asserted mid-RUN with strobes active -> next cycle all outputs at REQ-025 values; divide registers read back as all-ones period (256 cycles for DIV_WIDTH=8).

Source files
------------

// File: rtl/clock_manager_pkg.sv
// Shared types and default constants for the clock manager and its divider channels.
package clock_manager_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABILISE = 2'd1,
    RUN       = 2'd2
  } cm_state_e;

  localparam int DEF_NUM_CH        = 2;
  localparam int DEF_DIV_WIDTH     = 8;
  localparam int DEF_STABLE_CYCLES = 1024;

endpackage

// File: rtl/clock_divider_channel.sv
// One clock-enable strobe channel: shadow/active divide registers, period counter
// and a registered strobe that is high in the cycle the count equals the divide.
module clock_divider_channel
  import clock_manager_pkg::*;
#(
  parameter int DIV_WIDTH = DEF_DIV_WIDTH
) (
  input  logic                 clock_in,
  input  logic                 reset,
  input  logic                 run,
  input  logic                 run_next,
  input  logic                 en,
  input  logic                 div_load,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 strobe
);

  logic [DIV_WIDTH-1:0] active_reg, active_next;
  logic [DIV_WIDTH-1:0] shadow_reg, shadow_next;
  logic [DIV_WIDTH-1:0] cnt_reg, cnt_next;
  logic                 live_reg, live_next;
  logic                 strobe_reg, strobe_next;

  // All next values describe the upcoming cycle, so the registered strobe
  // lines up with the cycle in which the count equals the active divide.
  always_comb begin
    shadow_next = div_load ? div : shadow_reg;
    active_next = (!run || strobe_reg) ? shadow_next : active_reg;
    live_next   = run_next && en;
    cnt_next    = '0;
    if (live_reg && live_next && !strobe_reg) begin
      cnt_next = cnt_reg + DIV_WIDTH'(1);
    end
    strobe_next = live_next && (cnt_next == active_next);
  end

  always_ff @(posedge clock_in) begin
    if (reset) begin
      active_reg <= '1;
      shadow_reg <= '1;
      cnt_reg    <= '0;
      live_reg   <= 1'b0;
      strobe_reg <= 1'b0;
    end else begin
      active_reg <= active_next;
      shadow_reg <= shadow_next;
      cnt_reg    <= cnt_next;
      live_reg   <= live_next;
      strobe_reg <= strobe_next;
    end
  end

  assign strobe = strobe_reg;

endmodule

// File: rtl/clock_manager.sv
// PLL lock supervisor: synchronises locked, holds sys_reset until lock has been
// stable for STABLE_CYCLES, then drives per-channel clock-enable strobes.
module clock_manager
  import clock_manager_pkg::*;
#(
  parameter int NUM_CH        = DEF_NUM_CH,
  parameter int DIV_WIDTH     = DEF_DIV_WIDTH,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
) (
  input  logic                          clock_in,
  input  logic                          reset,
  input  logic                          locked,
  input  logic [NUM_CH*DIV_WIDTH-1:0]   div,
  input  logic [NUM_CH-1:0]             div_load,
  input  logic [NUM_CH-1:0]             ch_en,
  output logic                          sys_reset,
  output logic                          ready,
  output logic [NUM_CH-1:0]             strobe
);

  localparam int CW = $clog2(STABLE_CYCLES);

  cm_state_e     state_reg;
  logic [CW-1:0] stab_cnt_reg;
  logic          sync1_reg;
  logic          lock_s_reg;
  logic          sys_reset_reg;
  logic          ready_reg;
  logic          run_next;

  // Whether the upcoming cycle is a RUN cycle; lets the channels present
  // their first strobe on the very first RUN cycle.
  always_comb begin
    run_next = 1'b0;
    if (!reset && lock_s_reg) begin
      case (state_reg)
        STABILISE: run_next = (stab_cnt_reg == CW'(STABLE_CYCLES - 1));
        RUN:       run_next = 1'b1;
        default:   run_next = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clock_in) begin
    if (reset) begin
      state_reg     <= WAIT_LOCK;
      stab_cnt_reg  <= '0;
      sync1_reg     <= 1'b0;
      lock_s_reg    <= 1'b0;
      sys_reset_reg <= 1'b1;
      ready_reg     <= 1'b0;
    end else begin
      sync1_reg     <= locked;
      lock_s_reg    <= sync1_reg;
      sys_reset_reg <= !run_next;
      ready_reg     <= run_next;
      case (state_reg)
        WAIT_LOCK: begin
          stab_cnt_reg <= '0;
          if (lock_s_reg) state_reg <= STABILISE;
        end
        STABILISE: begin
          if (!lock_s_reg) begin
            state_reg    <= WAIT_LOCK;
            stab_cnt_reg <= '0;
          end else if (stab_cnt_reg == CW'(STABLE_CYCLES - 1)) begin
            state_reg    <= RUN;
            stab_cnt_reg <= '0;
          end else begin
            stab_cnt_reg <= stab_cnt_reg + CW'(1);
          end
        end
        RUN: begin
          stab_cnt_reg <= '0;
          if (!lock_s_reg) state_reg <= WAIT_LOCK;
        end
        default: begin
          state_reg    <= WAIT_LOCK;
          stab_cnt_reg <= '0;
        end
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      clock_divider_channel #(
        .DIV_WIDTH(DIV_WIDTH)
      ) u_ch (
        .clock_in (clock_in),
        .reset    (reset),
        .run      (ready_reg),
        .run_next (run_next),
        .en       (ch_en[gi]),
        .div_load (div_load[gi]),
        .div      (div[gi*DIV_WIDTH +: DIV_WIDTH]),
        .strobe   (strobe[gi])
      );
    end
  endgenerate

  assign sys_reset = sys_reset_reg;
  assign ready     = ready_reg;

endmodule
